// File: rtl/superh16_spec_ras.sv
// rtl/superh16_spec_ras.sv - speculative checkpointed return address stack
// Optional feature macro: RAS_COUNTER_EN (per-entry repeat counters).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   pred_valid/pred_ready           one predicted branch per cycle, accepted when both high
//   pred_is_call/pred_is_return     stack operation of the predicted branch
//   pred_pc                         branch PC; return address is pred_pc + INST_BYTES
//   ret_target/ret_target_valid     combinational return prediction from pre-op state
//   pred_ckpt_id                    checkpoint tag given to the accepted branch
//   recover_valid/recover_ckpt_id   mispredict: restore state as it was after that branch
//   commit_valid                    retire the oldest checkpoint
//   occupancy                       live stack entries
module superh16_spec_ras #(
    parameter int VADDR_W    = 48,
    parameter int DEPTH      = 32,
    parameter int CKPT_DEPTH = 16,
    parameter int INST_BYTES = 4,
    parameter int CTR_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pred_valid,
    output logic                          pred_ready,
    input  logic                          pred_is_call,
    input  logic                          pred_is_return,
    input  logic [VADDR_W-1:0]            pred_pc,
    output logic [VADDR_W-1:0]            ret_target,
    output logic                          ret_target_valid,
    output logic [$clog2(CKPT_DEPTH)-1:0] pred_ckpt_id,
    input  logic                          recover_valid,
    input  logic [$clog2(CKPT_DEPTH)-1:0] recover_ckpt_id,
    input  logic                          commit_valid,
    output logic [$clog2(DEPTH):0]        occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(CKPT_DEPTH);
    localparam int NW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [NW-1:0] CKPT_C  = NW'(CKPT_DEPTH);

    logic [VADDR_W-1:0] stack   [DEPTH];
    logic [AW-1:0]      ck_tos  [CKPT_DEPTH];
    logic [CW-1:0]      ck_count[CKPT_DEPTH];
    logic [VADDR_W-1:0] ck_top  [CKPT_DEPTH];

    logic [AW-1:0] tos;
    logic [CW-1:0] count;
    logic [IW-1:0] head, tail;
    logic [NW-1:0] num;

`ifdef RAS_COUNTER_EN
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    logic [CTR_W-1:0] ctr   [DEPTH];
    logic [CTR_W-1:0] ck_ctr[CKPT_DEPTH];
    logic             ctr_wr;
    logic [CTR_W-1:0] ctr_wdata;
    logic [CTR_W-1:0] ck_ctr_d;
`endif

    logic [AW-1:0]      top_idx, new_top_idx, rec_top_idx, wr_idx, tos_n;
    logic [CW-1:0]      count_n;
    logic [VADDR_W-1:0] ret_addr, ck_top_d;
    logic [IW-1:0]      rec_dist;
    logic [NW-1:0]      rec_num;
    logic               has_entry, accept, commit_eff, wr_en, do_push, do_pop;

    assign top_idx          = tos - 1'b1;
    assign has_entry        = (count != '0);
    assign ret_addr         = pred_pc + VADDR_W'(INST_BYTES);
    assign ret_target       = has_entry ? stack[top_idx] : ret_addr;
    assign ret_target_valid = has_entry;
    assign pred_ready       = (num != CKPT_C) && !recover_valid;
    assign pred_ckpt_id     = tail;
    assign occupancy        = count;
    assign accept           = pred_valid && pred_ready;
    assign commit_eff       = commit_valid && (num != '0);

    // Distance of the recovered checkpoint from head; kept entries are 0..rec_dist.
    assign rec_dist    = recover_ckpt_id - head;
    assign rec_num     = {1'b0, rec_dist} + NW'(1) - NW'(commit_eff);
    assign rec_top_idx = ck_tos[recover_ckpt_id] - 1'b1;

    always_comb begin
        tos_n   = tos;
        count_n = count;
        wr_en   = 1'b0;
        wr_idx  = tos;
        do_push = 1'b0;
        do_pop  = 1'b0;
`ifdef RAS_COUNTER_EN
        ctr_wr    = 1'b0;
        ctr_wdata = '0;
`endif
        if (accept) begin
            if (pred_is_call && pred_is_return && has_entry) begin
                // Tail call: the caller's return address replaces the top entry.
                wr_en  = 1'b1;
                wr_idx = top_idx;
`ifdef RAS_COUNTER_EN
                ctr_wr = 1'b1;
`endif
            end else if (pred_is_call) begin
`ifdef RAS_COUNTER_EN
                if (has_entry && stack[top_idx] == ret_addr && ctr[top_idx] != CTR_MAX) begin
                    ctr_wr    = 1'b1;
                    ctr_wdata = ctr[top_idx] + 1'b1;
                    wr_idx    = top_idx;
                end else begin
                    do_push = 1'b1;
                end
`else
                do_push = 1'b1;
`endif
            end else if (pred_is_return && has_entry) begin
`ifdef RAS_COUNTER_EN
                if (ctr[top_idx] != '0) begin
                    ctr_wr    = 1'b1;
                    ctr_wdata = ctr[top_idx] - 1'b1;
                    wr_idx    = top_idx;
                end else begin
                    do_pop = 1'b1;
                end
`else
                do_pop = 1'b1;
`endif
            end
        end
        if (do_push) begin
            // At full the slot at tos holds the oldest entry, so it is overwritten.
            wr_en   = 1'b1;
            wr_idx  = tos;
            tos_n   = tos + 1'b1;
            count_n = (count == DEPTH_C) ? count : count + 1'b1;
`ifdef RAS_COUNTER_EN
            ctr_wr  = 1'b1;
`endif
        end
        if (do_pop) begin
            tos_n   = top_idx;
            count_n = count - 1'b1;
        end
    end

    // Any write lands on the post-op top slot, so the written value is the new top.
    assign new_top_idx = tos_n - 1'b1;
    assign ck_top_d    = wr_en ? ret_addr : stack[new_top_idx];
`ifdef RAS_COUNTER_EN
    assign ck_ctr_d    = ctr_wr ? ctr_wdata : ctr[new_top_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos   <= '0;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            num   <= '0;
        end else if (recover_valid) begin
            tos   <= ck_tos[recover_ckpt_id];
            count <= ck_count[recover_ckpt_id];
            tail  <= recover_ckpt_id + 1'b1;
            head  <= head + IW'(commit_eff);
            num   <= rec_num;
        end else begin
            tos   <= tos_n;
            count <= count_n;
            tail  <= tail + IW'(accept);
            head  <= head + IW'(commit_eff);
            num   <= num + NW'(accept) - NW'(commit_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (recover_valid) begin
            stack[rec_top_idx] <= ck_top[recover_ckpt_id];
`ifdef RAS_COUNTER_EN
            ctr[rec_top_idx]   <= ck_ctr[recover_ckpt_id];
`endif
        end else begin
            if (wr_en) stack[wr_idx] <= ret_addr;
`ifdef RAS_COUNTER_EN
            if (ctr_wr) ctr[wr_idx] <= ctr_wdata;
`endif
        end
        if (accept) begin
            ck_tos[tail]   <= tos_n;
            ck_count[tail] <= count_n;
            ck_top[tail]   <= ck_top_d;
`ifdef RAS_COUNTER_EN
            ck_ctr[tail]   <= ck_ctr_d;
`endif
        end
    end

`ifndef SYNTHESIS
    // Recovery must name a live checkpoint.
    always_ff @(posedge clk) begin
        if (rst_n && recover_valid) assert ({1'b0, rec_dist} < num);
    end
`endif
endmodule

// File: tb/tb_superh16_spec_ras.sv
// tb/tb_superh16_spec_ras.sv - randomized self-checking bench for superh16_spec_ras
module tb_superh16_spec_ras;
    localparam int DEPTH = 32;
    localparam int CKPT  = 16;
    localparam int CTR_W = 3;
    localparam int CMAX  = (1 << CTR_W) - 1;
`ifdef RAS_COUNTER_EN
    localparam bit CTR_EN = 1'b1;
`else
    localparam bit CTR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0, pred_is_call = 1'b0, pred_is_return = 1'b0;
    logic [47:0] pred_pc = '0;
    logic        recover_valid = 1'b0, commit_valid = 1'b0;
    logic [3:0]  recover_ckpt_id = '0;
    logic        pred_ready, ret_target_valid;
    logic [47:0] ret_target;
    logic [3:0]  pred_ckpt_id;
    logic [5:0]  occupancy;

    superh16_spec_ras #(.VADDR_W(48), .DEPTH(DEPTH), .CKPT_DEPTH(CKPT), .INST_BYTES(4), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .pred_is_call(pred_is_call), .pred_is_return(pred_is_return), .pred_pc(pred_pc),
        .ret_target(ret_target), .ret_target_valid(ret_target_valid), .pred_ckpt_id(pred_ckpt_id),
        .recover_valid(recover_valid), .recover_ckpt_id(recover_ckpt_id),
        .commit_valid(commit_valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tos;
        int          cnt;
        logic [47:0] top;
        int          ctr;
    } ck_t;

    logic [47:0] m_stack [DEPTH];
    int          m_ctr   [DEPTH];
    int          m_tos, m_count, m_head;
    ck_t         q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tos = 0;
        m_count = 0;
        m_head = 0;
        q.delete();
    endtask

    // Applies one clock of the stack/checkpoint rules to the reference state.
    task automatic model_step(input bit v, input bit c, input bit r, input logic [47:0] pc,
                              input bit rec, input int rid, input bit com);
        logic [47:0] ra;
        int          top, had;
        ck_t         snap;
        ra  = pc + 48'd4;
        top = (m_tos + DEPTH - 1) % DEPTH;
        had = q.size();
        if (rec) begin
            int i;
            i = (rid - m_head + CKPT) % CKPT;
            m_tos = q[i].tos;
            m_count = q[i].cnt;
            m_stack[(m_tos + DEPTH - 1) % DEPTH] = q[i].top;
            m_ctr[(m_tos + DEPTH - 1) % DEPTH] = q[i].ctr;
            while (q.size() > i + 1) void'(q.pop_back());
            if (com) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % CKPT;
            end
        end else begin
            if (v && had != CKPT) begin
                if (c && r && m_count > 0) begin
                    m_stack[top] = ra;
                    m_ctr[top] = 0;
                end else if (c) begin
                    if (CTR_EN && m_count > 0 && m_stack[top] == ra && m_ctr[top] != CMAX) begin
                        m_ctr[top]++;
                    end else begin
                        m_stack[m_tos] = ra;
                        m_ctr[m_tos] = 0;
                        m_tos = (m_tos + 1) % DEPTH;
                        if (m_count < DEPTH) m_count++;
                    end
                end else if (r && m_count > 0) begin
                    if (CTR_EN && m_ctr[top] > 0) m_ctr[top]--;
                    else begin
                        m_tos = top;
                        m_count--;
                    end
                end
                snap.tos = m_tos;
                snap.cnt = m_count;
                snap.top = m_stack[(m_tos + DEPTH - 1) % DEPTH];
                snap.ctr = m_ctr[(m_tos + DEPTH - 1) % DEPTH];
                q.push_back(snap);
            end
            if (com && had > 0) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % CKPT;
            end
        end
    endtask

    // Drive one cycle, compare combinational/registered outputs to the model, clock, update model.
    task automatic cycle(input bit v, input bit c, input bit r, input logic [47:0] pc,
                         input bit rec, input int rid, input bit com);
        pred_valid = v;
        pred_is_call = c;
        pred_is_return = r;
        pred_pc = pc;
        recover_valid = rec;
        recover_ckpt_id = 4'(rid);
        commit_valid = com;
        #1;
        check_eq("ready", 64'(pred_ready), 64'(q.size() != CKPT && !rec));
        check_eq("rt_valid", 64'(ret_target_valid), 64'(m_count != 0));
        check_eq("ret_target", 64'(ret_target),
                 (m_count != 0) ? 64'(m_stack[(m_tos + DEPTH - 1) % DEPTH]) : 64'(pc + 48'd4));
        check_eq("ckpt_id", 64'(pred_ckpt_id), 64'((m_head + q.size()) % CKPT));
        check_eq("occupancy", 64'(occupancy), 64'(m_count));
        @(posedge clk);
        model_step(v, c, r, pc, rec, rid, com);
        #1;
    endtask

    task automatic idle();
        pred_valid = 0; pred_is_call = 0; pred_is_return = 0;
        recover_valid = 0; commit_valid = 0;
    endtask

    task automatic do_reset();
        idle();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_occ", 64'(occupancy), 64'd0);
        check_eq("rst_rtv", 64'(ret_target_valid), 64'd0);
        check_eq("rst_ready", 64'(pred_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_cycles(input int n, input int com_pct, input int rec_pct);
        for (int k = 0; k < n; k++) begin
            bit          v, c, r, rec, com;
            int          rid;
            logic [47:0] pc;
            v   = ($urandom % 100) < 75;
            c   = $urandom % 2;
            r   = $urandom % 2;
            pc  = 48'h8000 + 48'(($urandom % 6) * 4);
            if ($urandom % 8 == 0) pc = {$urandom, $urandom} & 48'hffff_ffff_fffc;
            rec = (q.size() > 0) && (($urandom % 100) < rec_pct);
            rid = (q.size() > 0) ? (m_head + ($urandom % q.size())) % CKPT : 0;
            com = (q.size() > 0) && (($urandom % 100) < com_pct);
            cycle(v, c, r, pc, rec, rid, com);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_stack[i] = '0;
            m_ctr[i] = 0;
        end
        model_reset();
        #3;
        check_eq("init_occ", 64'(occupancy), 64'd0);
        check_eq("init_ready", 64'(pred_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: reset asserted in the middle of traffic
        rand_cycles(40, 30, 5);
        do_reset();

        // T2: two calls then two returns
        cycle(1, 1, 0, 48'h100, 0, 0, 0);
        cycle(1, 1, 0, 48'h200, 0, 0, 0);
        check_eq("t2_top0", 64'(ret_target), 64'h204);
        check_eq("t2_occ2", 64'(occupancy), 64'd2);
        cycle(1, 0, 1, 48'h500, 0, 0, 0);
        check_eq("t2_top1", 64'(ret_target), 64'h104);
        check_eq("t2_occ1", 64'(occupancy), 64'd1);
        cycle(1, 0, 1, 48'h500, 0, 0, 0);
        check_eq("t2_occ0", 64'(occupancy), 64'd0);
        check_eq("t2_rtv", 64'(ret_target_valid), 64'd0);

        // T3: overflow wraps and drops the oldest entries
        do_reset();
        for (int k = 0; k < DEPTH + 2; k++) cycle(1, 1, 0, 48'h1000 + 48'(16 * k), 0, 0, q.size() > 0);
        check_eq("t3_full", 64'(occupancy), 64'(DEPTH));
        for (int k = DEPTH + 1; k >= 2; k--) begin
            check_eq("t3_pop", 64'(ret_target), 64'h1004 + 64'(16 * k));
            cycle(1, 0, 1, 48'h0, 0, 0, q.size() > 0);
        end
        check_eq("t3_empty", 64'(ret_target_valid), 64'd0);

        // T4: recovery to the first checkpoint
        do_reset();
        cycle(1, 1, 0, 48'h40, 0, 0, 0);
        cycle(1, 0, 1, 48'h60, 0, 0, 0);
        cycle(1, 1, 0, 48'h80, 0, 0, 0);
        cycle(1, 1, 0, 48'h90, 1, 0, 0);
        check_eq("t4_target", 64'(ret_target), 64'h44);
        check_eq("t4_occ", 64'(occupancy), 64'd1);
        check_eq("t4_id", 64'(pred_ckpt_id), 64'd1);

        // T5: checkpoint FIFO full, freed by one commit
        do_reset();
        for (int k = 0; k < CKPT; k++) cycle(1, 0, 0, 48'h700, 0, 0, 0);
        check_eq("t5_full", 64'(pred_ready), 64'd0);
        cycle(0, 0, 0, 48'h0, 0, 0, 1);
        check_eq("t5_freed", 64'(pred_ready), 64'd1);
        // recover to head with a simultaneous commit leaves the FIFO empty
        cycle(0, 0, 0, 48'h0, 1, m_head, 1);
        check_eq("t5_empty_id", 64'(pred_ckpt_id), 64'(m_head));

`ifdef RAS_COUNTER_EN
        // T6: repeated calls from one site fold into a counter
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1, 1, 0, 48'h300, 0, 0, 1);
        check_eq("t6_occ", 64'(occupancy), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check_eq("t6_tgt", 64'(ret_target), 64'h304);
            check_eq("t6_v", 64'(ret_target_valid), 64'd1);
            cycle(1, 0, 1, 48'h0, 0, 0, 1);
        end
        check_eq("t6_empty", 64'(ret_target_valid), 64'd0);
`endif

        // Randomized traffic: commit-heavy, then commit-starved to reach full
        do_reset();
        rand_cycles(1500, 45, 6);
        rand_cycles(1500, 10, 4);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
